// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake plus instruction-memory write port.
//   in_valid/in_data/in_ready : boot byte stream (source -> loader)
//   mem_we/mem_addr/mem_wdata : instruction-memory write port (loader -> memory)
// Modports: master = byte source / memory side, slave = loader side.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Receives a byte stream (4-byte LE word count N, then N LE words), writes
// each word to consecutive word addresses and holds the core in reset until
// the whole image is in memory.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// over the data bytes; a mismatch ends in the error state.
// Ports:
//   i_clk       system clock, rising edge
//   i_rst       synchronous active-high reset
//   bus         imem_loader_if.slave: in_valid/in_data/in_ready stream,
//               mem_we/mem_addr/mem_wdata write port
//   o_core_rst  core reset, high until load completes
//   o_done      image loaded, sticky until reset
//   o_err       load failed, sticky until reset
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic           i_clk,
  input  logic           i_rst,
  imem_loader_if.slave   bus,
  output logic           o_core_rst,
  output logic           o_done,
  output logic           o_err
);

  localparam int unsigned CNT_W    = ADDR_WIDTH + 1;
  localparam logic [32:0] CAPACITY = 33'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  state_t             w_fin_state;
  logic [1:0]         r_byte_cnt;
  logic [23:0]        r_shift;
  logic [CNT_W-1:0]   r_word_n;
  logic [CNT_W-1:0]   r_word_cnt;
  logic               r_mem_we;
  logic [31:0]        r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic               r_done;
  logic               r_err;
  logic               r_core_rst;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         r_csum;
`endif

  logic               w_ready;
  logic               w_accept;
  logic [31:0]        w_word;
  logic               w_byte_last;
  logic               w_word_last;
  logic               w_oversize;

  // Incoming byte lands in the top lane so the first byte ends up in [7:0].
  assign w_word      = {bus.in_data, r_shift};
  assign w_accept    = bus.in_valid && w_ready;
  assign w_byte_last = (r_byte_cnt == 2'd3);
  assign w_word_last = ((r_word_cnt + CNT_W'(1)) == r_word_n);
  assign w_oversize  = ({1'b0, w_word} > CAPACITY);

`ifdef LOADER_CHECKSUM_EN
  assign w_fin_state = S_CHK;
`else
  assign w_fin_state = S_DONE;
`endif

  // Ready only in the byte-consuming states, and never while reset is asserted.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_HDR, S_DATA: w_ready = !i_rst;
`ifdef LOADER_CHECKSUM_EN
      S_CHK:         w_ready = !i_rst;
`endif
      default:       w_ready = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_HDR;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HDR: begin
        if (w_accept && w_byte_last) begin
          if (w_word == 32'd0)  w_state_nxt = w_fin_state;
          else if (w_oversize)  w_state_nxt = S_ERR;
          else                  w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_accept && w_byte_last && w_word_last) w_state_nxt = w_fin_state;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_accept) w_state_nxt = (bus.in_data == r_csum) ? S_DONE : S_ERR;
      end
`endif
      default: w_state_nxt = r_state;
    endcase
  end

  // Datapath and registered outputs; status flags track the next state so
  // done/core_rst change together with the final write strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_byte_cnt  <= 2'd0;
      r_shift     <= 24'd0;
      r_word_n    <= '0;
      r_word_cnt  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_core_rst  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      r_csum      <= 8'd0;
`endif
    end else begin
      r_mem_we   <= 1'b0;
      r_done     <= (w_state_nxt == S_DONE);
      r_err      <= (w_state_nxt == S_ERR);
      r_core_rst <= (w_state_nxt != S_DONE);

      if (w_accept && (r_state == S_HDR || r_state == S_DATA)) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_shift    <= w_word[31:8];
      end

      if (w_accept && (r_state == S_HDR) && w_byte_last)
        r_word_n <= CNT_W'(w_word);

      if (w_accept && (r_state == S_DATA)) begin
`ifdef LOADER_CHECKSUM_EN
        r_csum <= r_csum ^ bus.in_data;
`endif
        if (w_byte_last) begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= 32'({r_word_cnt, 2'b00});
          r_mem_wdata <= w_word;
          r_word_cnt  <= r_word_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign o_core_rst    = r_core_rst;
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: self-checking bench for imem_loader (ADDR_WIDTH = 2).
// Images are built in the bench; an image-level model derives the expected
// writes and final status, and a monitor captures every write strobe.
module tb_imem_loader;

  localparam int unsigned AW  = 2;
  localparam int unsigned CAP = 4;

  typedef byte unsigned bq_t[$];
  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
    logic        done;
    logic        core_rst;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic core_rst, done, err;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  wr_t         wr_q[$];
  int          acc_q[$];
  logic [31:0] exp_words[$];
  bit          exp_done, exp_err;

  imem_loader_if bus ();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .bus        (bus),
    .o_core_rst (core_rst),
    .o_done     (done),
    .o_err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every write strobe together with the status seen in that cycle.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_t e;
      e.cyc = cyc; e.addr = bus.mem_addr; e.data = bus.mem_wdata;
      e.done = done; e.core_rst = core_rst;
      wr_q.push_back(e);
    end
  end

  function automatic bq_t make_image(input logic [31:0] n, input bit bad_cs);
    bq_t s;
    byte unsigned cs = 8'h00;
    logic [31:0] w;
    for (int b = 0; b < 4; b++) s.push_back(n[8*b +: 8]);
    if (n > CAP) return s;
    for (int k = 0; k < int'(n); k++) begin
      w = $urandom;
      for (int b = 0; b < 4; b++) begin
        s.push_back(w[8*b +: 8]);
        cs = cs ^ w[8*b +: 8];
      end
    end
    cs = cs ^ {7'd0, bad_cs};
`ifdef LOADER_CHECKSUM_EN
    s.push_back(cs);
`endif
    return s;
  endfunction

  function automatic bq_t nominal_image(input bit bad_cs);
    bq_t s;
    byte unsigned cs = 8'h00;
    s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h30, 8'h00};
    for (int i = 4; i < 12; i++) cs = cs ^ s[i];
    cs = cs ^ {7'd0, bad_cs};
`ifdef LOADER_CHECKSUM_EN
    s.push_back(cs);
`endif
    return s;
  endfunction

  // Image-level reference: expected write list and final outcome.
  task automatic model(input bq_t s);
    logic [31:0]  n;
    byte unsigned cs;
    n = {s[3], s[2], s[1], s[0]};
    exp_words.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    cs = 8'h00;
    if (n > CAP) begin
      exp_err = 1'b1;
      return;
    end
    for (int k = 0; k < int'(n); k++) begin
      exp_words.push_back({s[4+4*k+3], s[4+4*k+2], s[4+4*k+1], s[4+4*k]});
      for (int b = 0; b < 4; b++) cs = cs ^ s[4+4*k+b];
    end
`ifdef LOADER_CHECKSUM_EN
    if (s[4+4*int'(n)] == cs) exp_done = 1'b1;
    else                      exp_err  = 1'b1;
`else
    exp_done = 1'b1;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wr_q.delete();
    acc_q.delete();
  endtask

  // Offer bytes at negedges; gap 0 = continuous, 1 = every other cycle, 2 = random.
  // Returns at the negedge following the last accepting edge, with in_valid low.
  task automatic drive(input bq_t s, input int gap, output bit tmo);
    int   i = 0;
    int   guard = 0;
    logic v;
    tmo = 1'b0;
    while (i < s.size()) begin
      @(negedge clk);
      guard++;
      if (guard > 64 + 8 * s.size()) begin
        tmo = 1'b1;
        break;
      end
      case (gap)
        0:       v = 1'b1;
        1:       v = guard[0];
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      bus.in_valid = v;
      bus.in_data  = s[i];
      if (v && bus.in_ready === 1'b1) begin
        acc_q.push_back(cyc);
        i++;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b0 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0 ||
        done !== 1'b0 || err !== 1'b0 || core_rst !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: we=%b addr=%h wdata=%h done=%b err=%b core_rst=%b ready=%b, want 0 0 0 0 0 1 0",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, done, err, core_rst, bus.in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_load(input string name, input bq_t img, input int gap);
    bit tmo;
    int nw;
    int want_cyc;
    do_reset();
    model(img);
    drive(img, gap, tmo);
    repeat (4) @(negedge clk);
    checks++;
    if (tmo) begin
      errors++;
      $display("FAIL %s_timeout: accepted %0d bytes, want %0d", name, acc_q.size(), img.size());
    end
    checks++;
    if (wr_q.size() != exp_words.size()) begin
      errors++;
      $display("FAIL %s_write_count: got %0d want %0d", name, wr_q.size(), exp_words.size());
    end
    nw = (wr_q.size() < exp_words.size()) ? wr_q.size() : exp_words.size();
    for (int k = 0; k < nw; k++) begin
      want_cyc = (4*k + 7 < acc_q.size()) ? acc_q[4*k+7] + 1 : -1;
      checks++;
      if (wr_q[k].addr !== 32'(4*k) || wr_q[k].data !== exp_words[k] || wr_q[k].cyc != want_cyc) begin
        errors++;
        $display("FAIL %s_write%0d: addr=%h data=%h cyc=%0d, want addr=%h data=%h cyc=%0d",
                 name, k, wr_q[k].addr, wr_q[k].data, wr_q[k].cyc, 32'(4*k), exp_words[k], want_cyc);
      end
    end
    if (nw > 0 && nw == exp_words.size()) begin
      checks++;
`ifdef LOADER_CHECKSUM_EN
      if (wr_q[nw-1].done !== 1'b0 || wr_q[nw-1].core_rst !== 1'b1) begin
`else
      if (wr_q[nw-1].done !== 1'b1 || wr_q[nw-1].core_rst !== 1'b0) begin
`endif
        errors++;
        $display("FAIL %s_done_at_last_write: done=%b core_rst=%b", name, wr_q[nw-1].done, wr_q[nw-1].core_rst);
      end
    end
    checks++;
    if (done !== exp_done || err !== exp_err || core_rst !== logic'(!exp_done) ||
        bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_final: done=%b err=%b core_rst=%b ready=%b, want done=%b err=%b core_rst=%b ready=0",
               name, done, err, core_rst, bus.in_ready, exp_done, exp_err, !exp_done);
    end
  endtask

  task automatic test_nominal();
    test_load("nominal", nominal_image(1'b0), 0);
    checks++;
    if (wr_q.size() != 2 || wr_q[0].addr !== 32'h0 || wr_q[0].data !== 32'h00500513 ||
        wr_q[1].addr !== 32'h4 || wr_q[1].data !== 32'h00300593) begin
      errors++;
      $display("FAIL nominal_fixed_words: %0d writes, want 0:00500513 4:00300593", wr_q.size());
    end
  endtask

  task automatic test_backpressure();
    test_load("gaps", nominal_image(1'b0), 1);
  endtask

  task automatic test_oversize();
    bit tmo;
    do_reset();
    drive(make_image(32'd5, 1'b0), 0, tmo);
    checks++;
    if (tmo || err !== 1'b1 || bus.in_ready !== 1'b0 || core_rst !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL oversize_err: tmo=%b err=%b ready=%b core_rst=%b done=%b, want 0 1 0 1 0",
               tmo, err, bus.in_ready, core_rst, done);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (wr_q.size() != 0 || err !== 1'b1 || core_rst !== 1'b1) begin
      errors++;
      $display("FAIL oversize_no_write: writes=%0d err=%b core_rst=%b, want 0 1 1", wr_q.size(), err, core_rst);
    end
    test_load("full_capacity", make_image(32'd4, 1'b0), 2);
  endtask

  task automatic test_empty();
    bit tmo;
    do_reset();
    drive(make_image(32'd0, 1'b0), 0, tmo);
    checks++;
    if (tmo || done !== 1'b1 || core_rst !== 1'b0 || err !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL empty_done: tmo=%b done=%b core_rst=%b err=%b ready=%b, want 0 1 0 0 0",
               tmo, done, core_rst, err, bus.in_ready);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (wr_q.size() != 0) begin
      errors++;
      $display("FAIL empty_no_write: got %0d writes want 0", wr_q.size());
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    test_load("cs_good", nominal_image(1'b0), 1);
    test_load("cs_bad", nominal_image(1'b1), 0);
  endtask
`endif

  task automatic test_reset_mid();
    bq_t img;
    bq_t head;
    bit  tmo;
    img = nominal_image(1'b0);
    do_reset();
    for (int i = 0; i < 7; i++) head.push_back(img[i]);
    drive(head, 0, tmo);
    // The 4th byte of word 0 is offered in the same cycle reset is raised.
    bus.in_valid = 1'b1;
    bus.in_data  = img[7];
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b0 || done !== 1'b0 || err !== 1'b0 || core_rst !== 1'b1 ||
        bus.in_ready !== 1'b0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid: we=%b done=%b err=%b core_rst=%b ready=%b writes=%0d, want 0 0 0 1 0 0",
               bus.mem_we, done, err, core_rst, bus.in_ready, wr_q.size());
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    acc_q.delete();
    wr_q.delete();
    drive(img, 0, tmo);
    repeat (3) @(negedge clk);
    checks++;
    if (tmo || wr_q.size() != 2 || done !== 1'b1 || core_rst !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_reload: tmo=%b writes=%0d done=%b core_rst=%b, want 0 2 1 0",
               tmo, wr_q.size(), done, core_rst);
    end else begin
      checks++;
      if (wr_q[0].addr !== 32'h0 || wr_q[0].data !== 32'h00500513 ||
          wr_q[1].addr !== 32'h4 || wr_q[1].data !== 32'h00300593) begin
        errors++;
        $display("FAIL reset_mid_words: %h:%h %h:%h, want 0:00500513 4:00300593",
                 wr_q[0].addr, wr_q[0].data, wr_q[1].addr, wr_q[1].data);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] n;
    bit          bad;
    for (int it = 0; it < 10; it++) begin
      n = (it == 9) ? 32'h0001_0003 : 32'($urandom_range(0, 5));
`ifdef LOADER_CHECKSUM_EN
      bad = ($urandom_range(0, 1) == 1);
`else
      bad = 1'b0;
`endif
      test_load($sformatf("rand%0d", it), make_image(n, bad), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_nominal();
    test_backpressure();
    test_oversize();
    test_empty();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
